mcb_dat_seq: RTL
================

Name: mcb_dat_seq

Overview:
- Data-phase sequencer for the SDR SDRAM back-end. On each read or write command accepted from the command sequencer, it generates the d_wr_ld, d_dp_oe and d_dp_ie strobes that drive the data flip-flop stage.
- It also produces the host-side write-data request and read-data-valid strobes.
- Timing follows the configured CAS latency and burst length; the SDRAM command appears on the pins one cycle after cmd_*_go.

Parameters:
- BL_W, 2, width of the burst-length code (0=1, 1=2, 2=4, 3=8 beats).
- CNT_W, 4, width of the beat and latency counters; must hold BL_MAX+CL_MAX.
- CL_MIN, 2, minimum legal CAS latency.
- CL_MAX, 3, maximum legal CAS latency.

Ports:
- mcb_clk  in  1  single clock, rising edge.
- mcb_rst_n  in  1  asynchronous active-low reset.
- mcb_sclr_n  in  1  synchronous clear, active low.
- i_ready  in  1  init-complete flag; low forces the block idle.
- cfg_cas_lat  in  2  CAS latency; legal values 2 or 3.
- cfg_bl  in  BL_W  burst-length code.
- cmd_wr_go  in  1  single-cycle pulse: write command issued this cycle.
- cmd_rd_go  in  1  single-cycle pulse: read command issued this cycle.
- d_wr_ld  out  1  load write data into the output register.
- d_dp_oe  out  1  DQ output enable.
- d_dp_ie  out  1  capture DQ input.
- mcb_wreq  out  1  host must present mcb_wdat/mcb_wbe this cycle (equals d_wr_ld).
- mcb_rvld  out  1  mcb_rdat valid this cycle.
- dseq_busy  out  1  sequencer not idle; go pulses are not accepted.
- dseq_err  out  1  one-cycle pulse on a rejected go.

Behaviour:
- Reset (async, mcb_rst_n=0):
  - state=IDLE, all counters 0.
  - All outputs 0.
- Synchronous abort: mcb_sclr_n=0 or i_ready=0 forces the same values on the next edge, aborts any burst in progress, and ignores go pulses that cycle. dseq_err stays 0 during an abort.
- Config capture: cfg_cas_lat and cfg_bl are sampled only on an accepted go and held internally for the whole burst. BL = 1<<cfg_bl.
- State machine states: IDLE, WR, RD_LAT, RD_DAT, RD_TAIL.
- IDLE:
  - cmd_wr_go alone -> WR.
  - cmd_rd_go alone -> RD_LAT.
  - Both asserted -> stay IDLE and pulse dseq_err next cycle.
- Write, go at cycle T:
  - d_wr_ld and mcb_wreq are combinationally high in cycle T (Mealy on the accepted go), then registered high for T+1..T+BL-1.
  - d_dp_oe is registered high for T+1..T+BL.
  - State is WR from T+1 through T+BL, then IDLE at T+BL+1.
  - BL=1: d_wr_ld only at T; oe only at T+1.
- Read, go at cycle T:
  - RD_LAT counts CL cycles.
  - d_dp_ie is registered high for T+1+CL..T+CL+BL.
  - mcb_rvld is d_dp_ie delayed one cycle, matching the mcb_rdat register.
  - RD_TAIL covers the final rvld cycle; IDLE at T+CL+BL+2.
- dseq_busy = (state != IDLE). It is registered, so it is high from T+1 after an accepted go.
- A go pulse with state != IDLE is dropped and dseq_err pulses the next cycle. The burst in progress continues undisturbed.
- d_dp_oe and d_dp_ie are never high in the same cycle. Because go is accepted only in IDLE, the bus turnaround is at least one cycle.
- cfg_cas_lat outside CL_MIN..CL_MAX is treated as CL_MAX.
- The beat counter counts down from BL-1. Terminal condition is count==0; the counter never wraps.

Decomposition:
- Shared package, SDRC_LITE_MCB_PAR include:
  - burst-length code constants (BL1/BL2/BL4/BL8);
  - state encoding localparams;
  - CL_MIN and CL_MAX.
- One natural sub-module, mcb_dat_cnt: a loadable down-counter with a terminal-count flag, reused for the latency and beat counts.

Test Plan:
- Reset, then i_ready=1 and cfg_bl=2 (BL4), cmd_wr_go at T=10 -> d_wr_ld/mcb_wreq high at T10..13, d_dp_oe high at T11..14, dseq_busy high T11..14, idle at T15.
- CL=3, cfg_bl=3 (BL8), cmd_rd_go at T=20 -> d_dp_ie high T24..31, mcb_rvld high T25..32, idle at T33; oe is never high during this window.
- cmd_rd_go at T=40 (CL2, BL1), then cmd_wr_go at T=42 while busy -> write dropped, dseq_err high at T43, ie still at T43 only, rvld at T44.
- cmd_rd_go and cmd_wr_go together in IDLE -> no strobes, dseq_err one cycle, state stays IDLE.
- Mid-burst abort: drop i_ready during WR at beat 2 of BL8 -> all outputs 0 on the next edge, IDLE. Repeat with mcb_sclr_n=0 and with async mcb_rst_n mid-read -> outputs 0 immediately on reset assertion.
- cfg_bl changed from 3 to 0 during an active BL8 read -> the full 8 beats complete. The next read uses BL1: ie for 1 cycle.

Source files
------------

// File: rtl/mcb_dat_seq_pkg.sv
// Shared constants and state encoding for the MCB data-phase sequencer.
// Imported by the sequencer top and its counter.
package mcb_dat_seq_pkg;

    localparam int MCB_BL_W   = 2;
    localparam int MCB_CNT_W  = 4;
    localparam int MCB_CL_MIN = 2;
    localparam int MCB_CL_MAX = 3;

    // Burst-length codes; the beat count is 1 << code.
    localparam logic [MCB_BL_W-1:0] BL1 = 2'd0;
    localparam logic [MCB_BL_W-1:0] BL2 = 2'd1;
    localparam logic [MCB_BL_W-1:0] BL4 = 2'd2;
    localparam logic [MCB_BL_W-1:0] BL8 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_LAT  = 3'd2,
        ST_RD_DAT  = 3'd3,
        ST_RD_TAIL = 3'd4
    } dseq_state_e;

endpackage

// File: rtl/mcb_dat_cnt.sv
// Loadable down-counter with terminal-count flag; it holds at zero.
// Used by the sequencer for both the CAS-latency and the beat counts.
module mcb_dat_cnt #(
    parameter int W = 4
) (
    input  logic         mcb_clk,
    input  logic         mcb_rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mcb_dat_seq.sv
// Data-phase sequencer: turns accepted read/write commands into the DQ
// load/enable/capture strobes and the host-side wreq/rvld strobes.
module mcb_dat_seq
    import mcb_dat_seq_pkg::*;
#(
    parameter int BL_W   = MCB_BL_W,
    parameter int CNT_W  = MCB_CNT_W,
    parameter int CL_MIN = MCB_CL_MIN,
    parameter int CL_MAX = MCB_CL_MAX
) (
    input  logic            mcb_clk,
    input  logic            mcb_rst_n,
    input  logic            mcb_sclr_n,
    input  logic            i_ready,
    input  logic [1:0]      cfg_cas_lat,
    input  logic [BL_W-1:0] cfg_bl,
    input  logic            cmd_wr_go,
    input  logic            cmd_rd_go,
    output logic            d_wr_ld,
    output logic            d_dp_oe,
    output logic            d_dp_ie,
    output logic            mcb_wreq,
    output logic            mcb_rvld,
    output logic            dseq_busy,
    output logic            dseq_err
);

    dseq_state_e      state, state_nx;
    logic             abort, idle, acc_wr, acc_rd, rej;
    logic             beat_tc, lat_tc;
    logic [CNT_W-1:0] beat_ld_val, lat_ld_val;
    logic             oe_q, ie_q, rvld_q, busy_q, err_q;

    assign abort  = !mcb_sclr_n || !i_ready;
    assign idle   = (state == ST_IDLE);
    assign acc_wr = !abort && idle && cmd_wr_go && !cmd_rd_go;
    assign acc_rd = !abort && idle && cmd_rd_go && !cmd_wr_go;
    assign rej    = !abort && (cmd_wr_go || cmd_rd_go) &&
                    (!idle || (cmd_wr_go && cmd_rd_go));

    // Config is only consumed here, at the load of an accepted go; the
    // counters then carry it for the rest of the burst.
    assign beat_ld_val = (CNT_W'(1) << cfg_bl) - CNT_W'(1);

    always_comb begin
        if ((int'(cfg_cas_lat) < CL_MIN) || (int'(cfg_cas_lat) > CL_MAX)) begin
            lat_ld_val = CNT_W'(CL_MAX - 1);
        end else begin
            lat_ld_val = CNT_W'(cfg_cas_lat) - CNT_W'(1);
        end
    end

    mcb_dat_cnt #(.W(CNT_W)) u_beat_cnt (
        .mcb_clk   (mcb_clk),
        .mcb_rst_n (mcb_rst_n),
        .clr       (abort),
        .ld        (acc_wr || acc_rd),
        .ld_val    (beat_ld_val),
        .dec       ((state == ST_WR) || (state == ST_RD_DAT)),
        .tc        (beat_tc)
    );

    mcb_dat_cnt #(.W(CNT_W)) u_lat_cnt (
        .mcb_clk   (mcb_clk),
        .mcb_rst_n (mcb_rst_n),
        .clr       (abort),
        .ld        (acc_rd),
        .ld_val    (lat_ld_val),
        .dec       (state == ST_RD_LAT),
        .tc        (lat_tc)
    );

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_nx unassigned and infers a latch.
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (acc_wr) begin
                    state_nx = ST_WR;
                end else if (acc_rd) begin
                    state_nx = ST_RD_LAT;
                end
            end
            ST_WR:      if (beat_tc) state_nx = ST_IDLE;
            ST_RD_LAT:  if (lat_tc)  state_nx = ST_RD_DAT;
            ST_RD_DAT:  if (beat_tc) state_nx = ST_RD_TAIL;
            ST_RD_TAIL: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (abort) begin
            state_nx = ST_IDLE;
        end
    end

    // Pad-facing enables come straight from flops so they never glitch.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            state  <= ST_IDLE;
            oe_q   <= 1'b0;
            ie_q   <= 1'b0;
            rvld_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            oe_q   <= (state_nx == ST_WR);
            ie_q   <= (state_nx == ST_RD_DAT);
            rvld_q <= ie_q && !abort;
            busy_q <= (state_nx != ST_IDLE);
            err_q  <= rej;
        end
    end

    // First write beat is requested in the go cycle itself; later beats
    // follow while the beat counter has not yet reached its last beat.
    assign d_wr_ld   = acc_wr || ((state == ST_WR) && !beat_tc);
    assign mcb_wreq  = d_wr_ld;
    assign d_dp_oe   = oe_q;
    assign d_dp_ie   = ie_q;
    assign mcb_rvld  = rvld_q;
    assign dseq_busy = busy_q;
    assign dseq_err  = err_q;

endmodule
